// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the 2-way selector family of the 8-bit CPU component
// library: select encodings and default parameter values.
//
// Contents:
//   MUX_SEL_A / MUX_SEL_B : select encodings (0 -> operand a, 1 -> operand b)
//   MUX_WIDTH_DEF         : default data width
//   MUX_CNT_W_DEF         : default select-transition counter width
//   mux_sel_is_b()        : helper that decodes a select value
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MUX_SEL_A = 1'b0;
    localparam logic MUX_SEL_B = 1'b1;

    localparam int MUX_WIDTH_DEF = 1;
    localparam int MUX_CNT_W_DEF = 8;

    // Returns 1 when the select value chooses operand b. An X/Z select yields
    // X so that a ternary driven by this result merges the two operands.
    function automatic logic mux_sel_is_b(input logic sel);
        return (sel == MUX_SEL_B);
    endfunction

endpackage : mux_pkg

// File: rtl/mux_2_to_1_sel_toggle_counter.sv
// -----------------------------------------------------------------------------
// sel_toggle_counter
// Debug/coverage monitor for a mux select line. It remembers the select value
// sampled at the previous rising clock edge and counts every edge at which
// the current select differs from it. The count saturates at all-ones.
//
// Parameters:
//   CNT_W      : width of the transition counter
// Ports:
//   clk        : system clock, rising edge active
//   rst_n      : asynchronous active-low reset, clears history and count
//   sel_i      : select line being monitored
//   toggles_o  : number of select transitions since reset (registered)
// -----------------------------------------------------------------------------
module sel_toggle_counter
    import mux_pkg::*;
#(
    parameter int CNT_W = MUX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_i,
    output logic [CNT_W-1:0] toggles_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_incr(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    logic             sel_prev_q;
    logic             toggle_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Edge detection against the previous sample. The history register
    // resets to MUX_SEL_A, so a select held at 1 on the first edge after
    // reset counts as one transition.
    always_comb begin
        toggle_s = 1'b0;
        cnt_d    = cnt_q;
        if (sel_i != sel_prev_q) begin
            toggle_s = 1'b1;
            cnt_d    = sat_incr(cnt_q);
        end else begin
            toggle_s = 1'b0;
            cnt_d    = cnt_q;
        end
    end

    // Select history and transition count; both clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_prev_q <= MUX_SEL_A;
            cnt_q      <= CNT_ZERO;
        end else begin
            sel_prev_q <= sel_i;
            cnt_q      <= cnt_d;
        end
    end

    assign toggles_o = cnt_q;

endmodule : sel_toggle_counter

// File: rtl/mux_2_to_1.sv
// -----------------------------------------------------------------------------
// mux_2_to_1
// Two-input selector for the 8-bit CPU datapath: y = sel ? b : a.
// By default the data path is purely combinational and independent of clk and
// rst_n. Defining the macro MUX_2_TO_1_REG_OUT_EN registers y instead (one
// cycle of latency, reset value 0). A clocked monitor counts select
// transitions in both builds.
//
// Parameters:
//   WIDTH        : data width of a, b and y
//   CNT_W        : width of the saturating select-transition counter
// Ports:
//   clk          : system clock, rising edge active
//   rst_n        : asynchronous active-low reset
//   a            : operand selected when sel = 0
//   b            : operand selected when sel = 1
//   sel          : select, 0 -> a, 1 -> b
//   y            : selected operand
//   sel_toggles  : sel transitions since reset, saturating
// -----------------------------------------------------------------------------
module mux_2_to_1
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF,
    parameter int CNT_W = MUX_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] sel_toggles
);

    logic [WIDTH-1:0] sel_mux_s;

    // A continuous ternary (rather than an if) keeps the X-merge behaviour
    // for an unknown select: bits where a and b agree stay known.
    assign sel_mux_s = mux_sel_is_b(sel) ? b : a;

`ifdef MUX_2_TO_1_REG_OUT_EN
    logic [WIDTH-1:0] y_q;

    // Registered output option: y follows the selection one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= {WIDTH{1'b0}};
        end else begin
            y_q <= sel_mux_s;
        end
    end

    assign y = y_q;
`else
    assign y = sel_mux_s;
`endif

    sel_toggle_counter #(
        .CNT_W     (CNT_W)
    ) u_sel_toggle_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_i     (sel),
        .toggles_o (sel_toggles)
    );

endmodule : mux_2_to_1

// File: tb/tb_mux_2_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux_2_to_1
// Directed self-checking bench. Three instances: WIDTH=1, WIDTH=8 and a
// CNT_W=2 instance for counter saturation. Inputs change on the falling edge;
// outputs are sampled either on the falling edge or 1 ns after the rising one.
// -----------------------------------------------------------------------------
module tb_mux_2_to_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       a1, b1, s1, y1;
    logic [7:0] t1;

    logic [7:0] a8, b8, y8;
    logic       s8;
    logic [7:0] t8;

    logic       as, bs, ss, ys;
    logic [1:0] ts;

    int n_cmp = 0;
    int n_mis = 0;

    mux_2_to_1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(s1), .y(y1), .sel_toggles(t1)
    );

    mux_2_to_1 #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(s8), .y(y8), .sel_toggles(t8)
    );

    mux_2_to_1 #(.WIDTH(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .a(as), .b(bs), .sel(ss), .y(ys), .sel_toggles(ts)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one WIDTH=1 vector at a falling edge and check y.
    task automatic vec1(input logic a, input logic b, input logic s, input logic e, input string tag);
        @(negedge clk);
        a1 = a; b1 = b; s1 = s;
`ifndef MUX_2_TO_1_REG_OUT_EN
        #2;
        check_eq({tag, "_comb"}, {31'd0, y1}, {31'd0, e});
`endif
        @(negedge clk);
        check_eq(tag, {31'd0, y1}, {31'd0, e});
    endtask

    // Drive one WIDTH=8 vector at a falling edge and check y.
    task automatic vec8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [7:0] e, input string tag);
        @(negedge clk);
        a8 = a; b8 = b; s8 = s;
        @(negedge clk);
        check_eq(tag, {24'd0, y8}, {24'd0, e});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic       seq [5];
        logic [7:0] exp_cnt [5];
        seq     = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_cnt = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; s1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; s8 = 1'b0;
        as = 1'b0; bs = 1'b0; ss = 1'b0;

        // Reset state
        #1;
        check_eq("rst_t1", {24'd0, t1}, 32'd0);
        check_eq("rst_t8", {24'd0, t8}, 32'd0);
        check_eq("rst_ts", {30'd0, ts}, 32'd0);
`ifdef MUX_2_TO_1_REG_OUT_EN
        check_eq("rst_y8", {24'd0, y8}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 selection
        vec1(1'b0, 1'b1, 1'b0, 1'b0, "w1_a0b1_s0");
        vec1(1'b0, 1'b1, 1'b1, 1'b1, "w1_a0b1_s1");
        vec1(1'b1, 1'b0, 1'b0, 1'b1, "w1_a1b0_s0");
        vec1(1'b1, 1'b0, 1'b1, 1'b0, "w1_a1b0_s1");

        // WIDTH=8 selection
        vec8(8'h5A, 8'hC3, 1'b0, 8'h5A, "w8_s0");
        vec8(8'h5A, 8'hC3, 1'b1, 8'hC3, "w8_s1");

        // sel went 0,1,0,1 on dut1 and 0,1 on dut8
        check_eq("cnt_w1_vecs", {24'd0, t1}, 32'd3);
        check_eq("cnt_w8_vecs", {24'd0, t8}, 32'd1);

        // Toggle counting from a fresh reset: 0,1,1,0,1 -> 3
        @(negedge clk);
        rst_n = 1'b0;
        s1 = 1'b0;
        #1;
        check_eq("rst_mid_t1", {24'd0, t1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            s1 = seq[k];
            @(posedge clk);
            #1;
            check_eq($sformatf("seq_edge%0d", k), {24'd0, t1}, {24'd0, exp_cnt[k]});
        end

        // Glitch on sel that is gone before the next rising edge
        @(negedge clk);
        #1 s1 = 1'b0;
        #2 s1 = 1'b1;
        @(posedge clk);
        #1;
        check_eq("short_pulse", {24'd0, t1}, 32'd3);

        // Saturation with CNT_W=2
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ss = (k % 2 == 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            check_eq($sformatf("sat_edge%0d", k), {30'd0, ts}, (k < 3) ? (k + 1) : 32'd3);
        end

        // Reset asserted between edges: clears at once
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        as = 1'b1; bs = 1'b0; ss = 1'b0;
        #1;
        check_eq("async_rst_ts", {30'd0, ts}, 32'd0);
        check_eq("async_rst_t1", {24'd0, t1}, 32'd0);
`ifdef MUX_2_TO_1_REG_OUT_EN
        check_eq("async_rst_ys", {31'd0, ys}, 32'd0);
        check_eq("async_rst_y8", {24'd0, y8}, 32'd0);
`else
        check_eq("async_rst_ys", {31'd0, ys}, 32'd1);
        check_eq("async_rst_y8", {24'd0, y8}, 32'hC3);
`endif

        // Release, then new operands: registered build lags one edge
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h11; b8 = 8'h22; s8 = 1'b1;
        #1;
`ifdef MUX_2_TO_1_REG_OUT_EN
        check_eq("reg_hold", {24'd0, y8}, 32'd0);
`else
        check_eq("comb_now", {24'd0, y8}, 32'h22);
`endif
        @(posedge clk);
        #1;
        check_eq("after_edge", {24'd0, y8}, 32'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_mux_2_to_1
